// File: rtl/caches_pkg.sv
// rtl/caches_pkg.sv - shared cache/RAM types and arbiter state encoding
package caches_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFETCH = 2'd1,
    DREAD  = 2'd2,
    DWRITE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache to single-port RAM arbiter with starvation guard
module cache_mem_arbiter
  import caches_pkg::*;
#(
  parameter int unsigned MAX_DBURST = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        iwait,
  output logic        dwait,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  output logic        load_done,
  output logic        store_done
);

  localparam logic [3:0] BURST_MAX = 4'(MAX_DBURST);

  arb_state_t state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       load_done_q, load_done_d;
  logic       store_done_q, store_done_d;

  logic owner_req;
  logic complete;
  logic force_i;
  logic data_grant;

  // Request line of whichever cache currently owns the RAM.
  always_comb begin
    owner_req = 1'b0;
    case (state_q)
      IFETCH:  owner_req = iREN;
      DREAD:   owner_req = dREN;
      DWRITE:  owner_req = dWEN;
      default: owner_req = 1'b0;
    endcase
  end

  // A transfer finishes only if the owner is still asking when RAM reports ACCESS.
  assign complete   = owner_req && (ramstate == ACCESS);
  assign data_grant = (state_q == DREAD) || (state_q == DWRITE);
  // Once the data side has won MAX_DBURST times in a row, a waiting icache goes first.
  assign force_i    = iREN && (burst_q == BURST_MAX);

  // Registered state, starvation counter and completion pulses.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      burst_q      <= '0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_q      <= burst_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
    end
  end

  // Grant decision in IDLE; every grant returns to IDLE on completion or withdrawal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (dWEN && !force_i)      state_d = DWRITE;
        else if (dREN && !force_i) state_d = DREAD;
        else if (iREN)             state_d = IFETCH;
        else                       state_d = IDLE;
      end
      default: begin
        if (!owner_req || complete) state_d = IDLE;
      end
    endcase
  end

  // Starvation bookkeeping and next-cycle done pulses.
  always_comb begin
    burst_d      = burst_q;
    load_done_d  = complete && (state_q == DREAD);
    store_done_d = complete && (state_q == DWRITE);
    if (complete && (state_q == IFETCH)) begin
      burst_d = '0;
    end else if (complete && data_grant && iREN) begin
      if (burst_q < BURST_MAX) burst_d = burst_q + 4'd1;
    end else if ((state_q == IDLE) && !iREN) begin
      burst_d = '0;
    end
  end

  // RAM drive and cache handshakes; only the granted cache ever reaches the RAM.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      IFETCH: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iwait   = !complete;
      end
      DREAD: begin
        ramREN  = dREN;
        ramaddr = daddr;
        dwait   = !complete;
      end
      DWRITE: begin
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !complete;
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase
  end

  assign iload      = ramload;
  assign dload      = ramload;
  assign load_done  = load_done_q;
  assign store_done = store_done_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  import caches_pkg::*;

  localparam int MAXB = 4;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic        iwait, dwait, ramREN, ramWEN, load_done, store_done;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int failures = 0;

  cache_mem_arbiter #(.MAX_DBURST(MAXB)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramload(ramload), .ramstate(ramstate),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .load_done(load_done), .store_done(store_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM responder: `lat_cfg` non-ACCESS cycles before ACCESS, the first `err_cfg` reported as ERROR.
  int lat_cfg = 0;
  int err_cfg = 0;
  int run = 0;
  bit en_prev = 0;
  bit acc_prev = 0;

  always @(negedge CLK) begin
    en_prev  = ramREN | ramWEN;
    acc_prev = (ramstate == ACCESS);
  end

  always @(posedge CLK) begin
    run = (en_prev && !acc_prev) ? run + 1 : 0;
    #2;
    if (ramREN | ramWEN)
      ramstate = (run >= lat_cfg) ? ACCESS : ((run < err_cfg) ? ERROR : BUSY);
    else
      ramstate = FREE;
  end

  // Behavioural model: who owns the RAM (0 none, 1 icache, 2 data read, 3 data write).
  int m_owner = 0;
  int m_cnt = 0;
  bit m_ld = 0;
  bit m_sd = 0;

  function automatic int pick_owner();
    bit starved;
    starved = iREN && (m_cnt == MAXB);
    if (dWEN && !starved) return 3;
    if (dREN && !starved) return 2;
    if (iREN) return 1;
    return 0;
  endfunction

  always @(negedge CLK) begin
    bit req, done;
    bit e_ren, e_wen, e_iw, e_dw;
    logic [31:0] e_addr, e_store;
    int nxt;
    if (!nRST) begin
      m_owner = 0; m_cnt = 0; m_ld = 0; m_sd = 0;
    end
    req  = (m_owner == 1) ? iREN : (m_owner == 2) ? dREN : (m_owner == 3) ? dWEN : 1'b0;
    done = req && (ramstate == ACCESS);
    e_ren   = (m_owner == 1 || m_owner == 2) && req;
    e_wen   = (m_owner == 3) && req;
    e_addr  = (m_owner == 1) ? iaddr : (m_owner >= 2) ? daddr : 32'h0;
    e_store = (m_owner == 3) ? dstore : 32'h0;
    e_iw    = !(m_owner == 1 && done);
    e_dw    = !(m_owner >= 2 && done);
    chk("cmp_ramREN", ramREN, e_ren);
    chk("cmp_ramWEN", ramWEN, e_wen);
    chk("cmp_ramaddr", ramaddr, e_addr);
    chk("cmp_ramstore", ramstore, e_store);
    chk("cmp_iwait", iwait, e_iw);
    chk("cmp_dwait", dwait, e_dw);
    chk("cmp_iload", iload, ramload);
    chk("cmp_dload", dload, ramload);
    chk("cmp_load_done", load_done, m_ld);
    chk("cmp_store_done", store_done, m_sd);
    if (nRST) begin
      nxt = (m_owner == 0) ? pick_owner() : ((!req || done) ? 0 : m_owner);
      m_ld = done && (m_owner == 2);
      m_sd = done && (m_owner == 3);
      if (done && m_owner == 1) m_cnt = 0;
      else if (done && m_owner >= 2 && iREN) m_cnt = (m_cnt + 1 > MAXB) ? MAXB : m_cnt + 1;
      else if (m_owner == 0 && !iREN) m_cnt = 0;
      m_owner = nxt;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic obs();
    @(negedge CLK);
  endtask

  int order[$];
  int exp_order[7] = '{2, 2, 2, 2, 1, 2, 2};
  int dn;
  bit idone;

  initial begin
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
    iaddr = 0; daddr = 0; dstore = 0; ramload = 32'hDEADBEEF; ramstate = FREE;
    repeat (2) obs();
    chk("rst_iwait", iwait, 1);
    chk("rst_dwait", dwait, 1);
    chk("rst_ramREN", ramREN, 0);
    chk("rst_ramWEN", ramWEN, 0);
    chk("rst_ramaddr", ramaddr, 0);
    chk("rst_load_done", load_done, 0);
    step(); nRST = 1'b1; obs();

    // Icache only, RAM answers after two BUSY cycles.
    lat_cfg = 2; err_cfg = 0;
    step(); iREN = 1; iaddr = 32'h100; obs();
    chk("t1_c0_ramREN", ramREN, 0);
    step(); obs();
    chk("t1_c1_ramREN", ramREN, 1);
    chk("t1_c1_ramaddr", ramaddr, 32'h100);
    chk("t1_c1_iwait", iwait, 1);
    step(); obs();
    chk("t1_c2_iwait", iwait, 1);
    step(); obs();
    chk("t1_c3_iwait", iwait, 0);
    chk("t1_c3_iload", iload, 32'hDEADBEEF);
    step(); iREN = 0; obs();
    chk("t1_load_done", load_done, 0);
    chk("t1_store_done", store_done, 0);
    step(); obs();

    // Simultaneous icache and dcache read: data first, one IDLE bubble, then icache.
    lat_cfg = 0; ramload = 32'h0BADF00D;
    step(); iREN = 1; dREN = 1; iaddr = 32'h104; daddr = 32'h200; obs();
    step(); obs();
    chk("t2_c1_ramaddr", ramaddr, 32'h200);
    chk("t2_c1_dwait", dwait, 0);
    chk("t2_c1_iwait", iwait, 1);
    step(); dREN = 0; obs();
    chk("t2_c2_load_done", load_done, 1);
    chk("t2_c2_bubble_ramREN", ramREN, 0);
    step(); obs();
    chk("t2_c3_ramaddr", ramaddr, 32'h104);
    chk("t2_c3_iwait", iwait, 0);
    step(); iREN = 0; obs();

    // Read and write together is a write.
    lat_cfg = 1;
    step(); dREN = 1; dWEN = 1; daddr = 32'h300; dstore = 32'h12345678; obs();
    step(); obs();
    chk("t3_ramWEN", ramWEN, 1);
    chk("t3_ramREN", ramREN, 0);
    chk("t3_ramstore", ramstore, 32'h12345678);
    chk("t3_c1_dwait", dwait, 1);
    step(); obs();
    chk("t3_c2_dwait", dwait, 0);
    step(); dREN = 0; dWEN = 0; obs();
    chk("t3_store_done", store_done, 1);
    chk("t3_load_done", load_done, 0);
    step(); obs();
    chk("t3_store_done_off", store_done, 0);

    // Starvation: six data reads against a waiting icache.
    lat_cfg = 0; dn = 0; idone = 0;
    step(); iREN = 1; dREN = 1; iaddr = 32'h400; daddr = 32'h500;
    for (int c = 0; c < 60 && !(dn >= 6 && idone); c++) begin
      obs();
      if (!dwait) begin order.push_back(2); dn++; end
      if (!iwait) begin order.push_back(1); idone = 1; end
      step();
      if (dn >= 6) dREN = 0;
      if (idone) iREN = 0;
    end
    chk("t4_grant_count", order.size(), 7);
    if (order.size() == 7)
      for (int k = 0; k < 7; k++) chk($sformatf("t4_grant_%0d", k), order[k], exp_order[k]);
    obs();

    // Withdrawal while BUSY.
    lat_cfg = 99;
    step(); dREN = 1; daddr = 32'h600; obs();
    step(); obs();
    chk("t5_c1_ramREN", ramREN, 1);
    step(); dREN = 0; obs();
    chk("t5_drop_ramREN", ramREN, 0);
    chk("t5_drop_ramaddr", ramaddr, 32'h600);
    chk("t5_drop_dwait", dwait, 1);
    step(); obs();
    chk("t5_idle_ramaddr", ramaddr, 0);
    chk("t5_no_load_done", load_done, 0);
    step(); obs();
    chk("t5_no_load_done2", load_done, 0);

    // ERROR for three cycles, then ACCESS.
    lat_cfg = 3; err_cfg = 3;
    step(); dREN = 1; daddr = 32'h700; obs();
    for (int k = 0; k < 3; k++) begin
      step(); obs();
      chk($sformatf("t5e_ramREN_%0d", k), ramREN, 1);
      chk($sformatf("t5e_dwait_%0d", k), dwait, 1);
    end
    step(); obs();
    chk("t5e_dwait_done", dwait, 0);
    step(); dREN = 0; obs();
    chk("t5e_load_done", load_done, 1);
    err_cfg = 0;

    // Reset in the middle of a write, then a fresh read.
    lat_cfg = 99;
    step(); dWEN = 1; daddr = 32'h800; dstore = 32'hAA; obs();
    step(); obs();
    chk("t6_ramWEN", ramWEN, 1);
    step(); nRST = 0; obs();
    chk("t6_rst_ramWEN", ramWEN, 0);
    chk("t6_rst_dwait", dwait, 1);
    chk("t6_rst_ramstore", ramstore, 0);
    step(); nRST = 1; dWEN = 0; dREN = 1; daddr = 32'h900; lat_cfg = 0; obs();
    step(); obs();
    chk("t6_ramaddr", ramaddr, 32'h900);
    chk("t6_dwait", dwait, 0);
    step(); dREN = 0; obs();
    chk("t6_load_done", load_done, 1);
    chk("t6_store_done", store_done, 0);
    step(); obs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Memory controller that implements the cc side of the cache/RAM arbitration interface.
- Takes instruction-fetch and data read/write requests from the icache and dcache, grants one at a time to the single-ported RAM, and returns wait, load data and completion pulses.
- Sits directly downstream of both caches and directly upstream of the RAM model.
- Data requests have priority, bounded by a starvation limit that protects instruction fetch.

Parameters:
- MAX_DBURST, 4: consecutive completed data accesses with iREN pending before icache is forced a grant (1..15).

Ports:
- CLK  input  1  system clock, rising edge
- nRST  input  1  reset, asynchronous, active-low
- iREN  input  1  icache read request
- iaddr  input  32  icache word address
- dREN  input  1  dcache read request
- dWEN  input  1  dcache write request
- daddr  input  32  dcache word address
- dstore  input  32  dcache write data
- ramload  input  32  RAM read data
- ramstate  input  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- iwait  output  1  icache must hold its request
- dwait  output  1  dcache must hold its request
- iload  output  32  instruction read data
- dload  output  32  data read data
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- load_done  output  1  one-cycle pulse after a data read completes
- store_done  output  1  one-cycle pulse after a data write completes

Behaviour:
- Reset values, held for as long as nRST is low and taking effect immediately on assertion:
  - FSM in IDLE, starvation counter 0.
  - load_done = 0, store_done = 0.
  - ramREN = 0, ramWEN = 0, ramaddr = 0, ramstore = 0.
  - iwait = 1, dwait = 1.
- FSM states are IDLE, IFETCH, DREAD and DWRITE; state and grant are registered.
- IDLE:
  - No RAM enables are driven; iwait = dwait = 1.
  - Next state, evaluated in priority order:
    - dWEN -> DWRITE, unless forced icache.
    - dREN -> DREAD, unless forced icache.
    - iREN -> IFETCH.
    - Otherwise stay in IDLE.
  - Forced icache means iREN is high and the counter equals MAX_DBURST.
  - When dREN and dWEN are both high, the request is treated as a write (DWRITE).
- IFETCH:
  - ramREN = iREN, ramaddr = iaddr.
- DREAD:
  - ramREN = dREN, ramaddr = daddr.
- DWRITE:
  - ramWEN = dWEN, ramaddr = daddr, ramstore = dstore.
- RAM enables are combinational: (state matches) AND (owning request still asserted). Enables and addresses are never driven for the non-granted cache.
- Completion:
  - In a grant state with ramstate == ACCESS, the owner's wait goes to 0 in that same cycle and the FSM returns to IDLE.
  - Every other cycle the owner's wait is 1, and the non-owner's wait is always 1.
- Data return: iload = ramload and dload = ramload at all times; caches sample only while their wait is 0.
- Completion pulses: load_done or store_done is a registered one-cycle pulse in the cycle after the DREAD or DWRITE completion cycle. Both are never high together.
- Latency:
  - One arbitration cycle in IDLE, then RAM latency.
  - With ACCESS on the first enabled cycle: request at cycle 0, grant at cycle 1, wait low at cycle 1, done pulse at cycle 2.
  - Back-to-back requests always pass through IDLE, so there is a one-cycle bubble between transactions.
- Withdrawal: if the owner drops its request before ACCESS, enables drop in the same cycle, the FSM returns to IDLE next cycle, and no done pulse is produced.
- ERROR or BUSY/FREE: stay in the grant state with enables held and wait = 1. An ERROR is simply retried; no error output exists.
- Starvation counter (4 bits, saturating at MAX_DBURST):
  - Increments on each data completion while iREN = 1.
  - Clears on an IFETCH completion.
  - Clears when iREN = 0 in IDLE.
- Reset asserted mid-transaction: all of the above reset values apply immediately, and the FSM restarts from IDLE.

Decomposition:
- caches_pkg: word_t (32-bit), ramstate_t, and a new arb_state_t enum (IDLE, IFETCH, DREAD, DWRITE).
- MAX_DBURST remains a module parameter.
- Single module, no sub-module; it binds to the existing interface cc modport plus CLK/nRST.

Test Plan:
- Icache only: iREN=1, iaddr=0x100, RAM returns ACCESS 2 cycles after ramREN with ramload=0xDEADBEEF -> ramREN high from cycle 1, iwait low in exactly one cycle with iload=0xDEADBEEF, load_done and store_done stay 0.
- Simultaneous: iREN=1 and dREN=1 (daddr=0x200) asserted together -> DREAD granted first with ramaddr=0x200, load_done pulses one cycle after dwait low, then IFETCH granted after one IDLE bubble.
- Write with read conflict: dREN=1 and dWEN=1, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678, store_done pulses once, load_done stays 0.
- Starvation: iREN held high while the dcache issues 6 back-to-back reads, MAX_DBURST=4 -> the 5th grant is IFETCH; after the icache completes, data grants resume.
- Withdrawal and error: dREN dropped while ramstate=BUSY -> ramREN=0 in the same cycle, IDLE next cycle, no load_done. Separately, ramstate=ERROR for 3 cycles -> enables held, dwait=1 throughout, then ACCESS completes normally.
- Reset mid-op: nRST low during DWRITE -> ramWEN=0 and dwait=1 immediately; after release, a fresh dREN completes correctly.
